// File: rtl/seq_fuse_detect.sv
// seq_fuse_detect: fuses buffered uop windows into case tokens from len_table_pkg.
// Build option SEQ_FUSE_IMM_CHECK_EN also matches immediates against the tables.
package len_table_pkg;

    typedef enum logic [2:0] {
        OP_NOP,
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_IMUL,
        OP_INC,
        OP_SHL
    } op_t;

    localparam int N_CASE  = 3;
    localparam int MAX_LEN = 2;

    localparam int LEN_LUT [N_CASE] = '{2, 2, 2};

    localparam op_t OPS_LUT [N_CASE][MAX_LEN] = '{
        '{OP_IMUL, OP_ADD},
        '{OP_AND,  OP_AND},
        '{OP_INC,  OP_SHL}
    };

`ifdef SEQ_FUSE_IMM_CHECK_EN
    localparam logic [31:0] IMM_LUT [N_CASE][MAX_LEN] = '{
        '{32'd0, 32'd0},
        '{32'd0, 32'd0},
        '{32'd1, 32'd1}
    };

    localparam logic USE_IMM_LUT [N_CASE][MAX_LEN] = '{
        '{1'b0, 1'b0},
        '{1'b0, 1'b0},
        '{1'b1, 1'b1}
    };
`endif

endpackage

module seq_fuse_detect
    import len_table_pkg::*;
#(
    parameter int  STALL_TO = 8,
    localparam int CW = (N_CASE > 1) ? $clog2(N_CASE) : 1,
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  op_t           in_op,
    input  logic [31:0]   in_imm,
    input  logic          in_use_imm,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_fused,
    output logic [CW-1:0] out_case,
    output logic [LW-1:0] out_len,
    output op_t           out_op,
    output logic [31:0]   out_imm,
    output logic          out_use_imm
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_EMIT,
        S_DRAIN
    } state_t;

    state_t        r_state;
    state_t        w_state_n;

    op_t           r_op  [MAX_LEN];
    logic [31:0]   r_imm [MAX_LEN];
    logic          r_uim [MAX_LEN];
    logic [LW-1:0] r_cnt;
    logic [7:0]    r_stall;

    logic          r_out_valid;
    logic          r_out_fused;
    logic [CW-1:0] r_out_case;
    logic [LW-1:0] r_out_len;
    op_t           r_out_op;
    logic [31:0]   r_out_imm;
    logic          r_out_uim;

    op_t           w_op   [MAX_LEN];
    logic [31:0]   w_imm  [MAX_LEN];
    logic          w_uim  [MAX_LEN];
    op_t           w_nop  [MAX_LEN];
    logic [31:0]   w_nimm [MAX_LEN];
    logic          w_nuim [MAX_LEN];

    logic          w_acc;
    logic [LW-1:0] w_vcnt;
    logic [LW-1:0] w_pop;
    logic [LW-1:0] w_cnt_n;
    logic          w_full;
    logic          w_pfx;
    logic          w_m;
    logic          w_hit;
    logic [CW-1:0] w_case;
    logic [LW-1:0] w_flen;
    logic          w_free;
    logic          w_fuse;
    logic          w_tmo;
    logic          w_single;
    logic          w_dec;
    logic          w_load;
    logic          w_pend;
    logic [7:0]    w_stall_n;

    assign in_ready = (r_cnt < LW'(MAX_LEN)) && !flush;
    assign w_acc    = in_valid && in_ready;
    assign w_vcnt   = r_cnt + LW'(w_acc);

    // Decisions see the window with this cycle's accepted uop appended.
    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) begin
            w_op[i]  = r_op[i];
            w_imm[i] = r_imm[i];
            w_uim[i] = r_uim[i];
            if (i >= int'(r_cnt)) begin
                w_op[i]  = in_op;
                w_imm[i] = in_imm;
                w_uim[i] = in_use_imm;
            end
        end
    end

    // Descending scan so the lowest matching case index wins.
    always_comb begin
        w_full = 1'b0;
        w_pfx  = 1'b0;
        w_case = '0;
        w_flen = '0;
        w_m    = 1'b0;
        w_hit  = 1'b0;
        for (int c = N_CASE - 1; c >= 0; c--) begin
            w_m = 1'b1;
            for (int i = 0; i < MAX_LEN; i++) begin
`ifdef SEQ_FUSE_IMM_CHECK_EN
                w_hit = (w_op[i] == OPS_LUT[c][i])
                     && (w_uim[i] == USE_IMM_LUT[c][i])
                     && (!USE_IMM_LUT[c][i]
                         || (w_imm[i] == IMM_LUT[c][i]));
`else
                w_hit = (w_op[i] == OPS_LUT[c][i]);
`endif
                if ((i < LEN_LUT[c]) && (i < int'(w_vcnt)) && !w_hit) begin
                    w_m = 1'b0;
                end
            end
            if (w_m && (int'(w_vcnt) >= LEN_LUT[c])) begin
                w_full = 1'b1;
                w_case = CW'(c);
                w_flen = LW'(LEN_LUT[c]);
            end
            if (w_m && (w_vcnt != '0) && (int'(w_vcnt) < LEN_LUT[c])) begin
                w_pfx = 1'b1;
            end
        end
    end

    assign w_free   = !r_out_valid || out_ready;
    assign w_fuse   = !flush && w_full;
    assign w_tmo    = !flush && !w_full && w_pfx && !in_valid
                   && ((int'(r_stall) + 1) >= STALL_TO);
    assign w_single = (w_vcnt != '0) && !w_fuse
                   && (flush || !w_pfx || w_tmo);
    assign w_dec    = w_fuse || w_single;
    assign w_load   = w_dec && w_free;
    assign w_pend   = w_dec && !w_free;
    assign w_pop    = !w_load ? '0 : (w_fuse ? w_flen : LW'(1));
    assign w_cnt_n  = w_vcnt - w_pop;

    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) begin
            w_nop[i]  = w_op[i];
            w_nimm[i] = w_imm[i];
            w_nuim[i] = w_uim[i];
            for (int j = 0; j < MAX_LEN; j++) begin
                if (j == i + int'(w_pop)) begin
                    w_nop[i]  = w_op[j];
                    w_nimm[i] = w_imm[j];
                    w_nuim[i] = w_uim[j];
                end
            end
        end
    end

    // Saturates at STALL_TO so a held timeout survives a stalled output.
    always_comb begin
        w_stall_n = r_stall;
        if (w_acc || w_load || (w_cnt_n == '0)) begin
            w_stall_n = '0;
        end else if (!w_full && w_pfx && !in_valid && !flush) begin
            if ((int'(r_stall) + 1) >= STALL_TO) begin
                w_stall_n = 8'(STALL_TO);
            end else begin
                w_stall_n = r_stall + 8'd1;
            end
        end
    end

    always_comb begin
        w_state_n = r_state;
        if (flush) begin
            w_state_n = S_DRAIN;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_pend) begin
                        w_state_n = S_EMIT;
                    end else if (w_cnt_n != '0) begin
                        w_state_n = S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (w_tmo) begin
                        w_state_n = S_DRAIN;
                    end else if (w_pend) begin
                        w_state_n = S_EMIT;
                    end else if (w_cnt_n == '0) begin
                        w_state_n = S_IDLE;
                    end
                end
                S_EMIT: begin
                    if (w_free) begin
                        w_state_n = (w_cnt_n == '0) ? S_IDLE : S_COLLECT;
                    end
                end
                S_DRAIN: begin
                    if (w_cnt_n == '0) begin
                        w_state_n = S_IDLE;
                    end else if (w_pend) begin
                        w_state_n = S_EMIT;
                    end else begin
                        w_state_n = S_COLLECT;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_stall     <= '0;
            for (int i = 0; i < MAX_LEN; i++) begin
                r_op[i]  <= OP_NOP;
                r_imm[i] <= '0;
                r_uim[i] <= 1'b0;
            end
            r_out_valid <= 1'b0;
            r_out_fused <= 1'b0;
            r_out_case  <= '0;
            r_out_len   <= '0;
            r_out_op    <= OP_NOP;
            r_out_imm   <= '0;
            r_out_uim   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_stall <= w_stall_n;
            for (int i = 0; i < MAX_LEN; i++) begin
                r_op[i]  <= w_nop[i];
                r_imm[i] <= w_nimm[i];
                r_uim[i] <= w_nuim[i];
            end
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_fused <= w_fuse;
                r_out_case  <= w_fuse ? w_case : '0;
                r_out_len   <= w_fuse ? w_flen : LW'(1);
                r_out_op    <= w_op[0];
                r_out_imm   <= w_imm[0];
                r_out_uim   <= w_uim[0];
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_fused   = r_out_fused;
    assign out_case    = r_out_case;
    assign out_len     = r_out_len;
    assign out_op      = r_out_op;
    assign out_imm     = r_out_imm;
    assign out_use_imm = r_out_uim;

endmodule

// File: tb/tb_seq_fuse_detect.sv
// tb_seq_fuse_detect: directed and random stimulus for seq_fuse_detect
// checked every cycle against a queue-based model of the fusion rules.
module tb_seq_fuse_detect;
    import len_table_pkg::*;

    localparam int STALL_TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    op_t         in_op;
    logic [31:0] in_imm;
    logic        in_use_imm;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic        out_fused;
    logic [1:0]  out_case;
    logic [1:0]  out_len;
    op_t         out_op;
    logic [31:0] out_imm;
    logic        out_use_imm;

    always #5 clk = ~clk;

    seq_fuse_detect #(.STALL_TO(STALL_TO)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_op(in_op),
        .in_imm(in_imm),
        .in_use_imm(in_use_imm),
        .flush(flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_fused(out_fused),
        .out_case(out_case),
        .out_len(out_len),
        .out_op(out_op),
        .out_imm(out_imm),
        .out_use_imm(out_use_imm)
    );

    typedef struct {
        op_t         op;
        logic [31:0] imm;
        logic        uim;
    } uop_t;

    uop_t mq[$];
    bit   ms_valid;
    bit   ms_fused;
    int   ms_case;
    int   ms_len;
    uop_t ms_head;
    int   m_stall;

    int n_vec = 0;
    int n_err = 0;
    int n_acc = 0;
    int n_out = 0;

    function automatic void chk(input string name, input longint act,
                                input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endfunction

    function automatic bit elem_ok(input int c, input int i, input uop_t u);
`ifdef SEQ_FUSE_IMM_CHECK_EN
        if (u.uim != USE_IMM_LUT[c][i]) return 1'b0;
        if (USE_IMM_LUT[c][i] && (u.imm != IMM_LUT[c][i])) return 1'b0;
`endif
        return u.op == OPS_LUT[c][i];
    endfunction

    task automatic model_reset();
        mq.delete();
        ms_valid = 1'b0;
        ms_fused = 1'b0;
        ms_case  = 0;
        ms_len   = 0;
        ms_head.op  = OP_NOP;
        ms_head.imm = '0;
        ms_head.uim = 1'b0;
        m_stall  = 0;
        n_acc    = 0;
        n_out    = 0;
    endtask

    task automatic model_step(input bit v, input uop_t u, input bit ordy,
                              input bit fl);
        uop_t view[$];
        bit   acc;
        bit   pfx;
        bit   fz;
        bit   tmo;
        bit   dec;
        int   fc;
        int   pop;
        acc  = v && (mq.size() < MAX_LEN) && !fl;
        view = mq;
        if (acc) begin
            view.push_back(u);
            n_acc++;
        end
        fz  = 1'b0;
        fc  = 0;
        pfx = 1'b0;
        if (!fl) begin
            for (int c = 0; c < N_CASE; c++) begin
                int k;
                bit ok;
                k  = (view.size() < LEN_LUT[c]) ? view.size() : LEN_LUT[c];
                ok = 1'b1;
                for (int i = 0; i < k; i++)
                    if (!elem_ok(c, i, view[i])) ok = 1'b0;
                if (ok && (k == LEN_LUT[c]) && !fz) begin
                    fz = 1'b1;
                    fc = c;
                end else if (ok && (k > 0) && (k < LEN_LUT[c])) begin
                    pfx = 1'b1;
                end
            end
        end
        tmo = !fl && !fz && pfx && !v && (m_stall + 1 >= STALL_TO);
        dec = (view.size() > 0) && (fz || fl || !pfx || tmo);
        pop = 0;
        if (dec && (!ms_valid || ordy)) begin
            ms_valid = 1'b1;
            ms_fused = fz;
            ms_case  = fz ? fc : 0;
            ms_len   = fz ? LEN_LUT[fc] : 1;
            ms_head  = view[0];
            pop      = ms_len;
        end else if (ordy) begin
            ms_valid = 1'b0;
        end
        repeat (pop) void'(view.pop_front());
        mq = view;
        if (acc || (pop > 0) || (mq.size() == 0)) begin
            m_stall = 0;
        end else if (!fz && pfx && !v && !fl) begin
            m_stall = (m_stall + 1 > STALL_TO) ? STALL_TO : m_stall + 1;
        end
    endtask

    task automatic compare();
        chk("out_valid", out_valid, ms_valid);
        if (ms_valid) begin
            chk("out_fused", out_fused, ms_fused);
            chk("out_case", out_case, ms_case);
            chk("out_len", out_len, ms_len);
            chk("out_op", out_op, ms_head.op);
            chk("out_imm", out_imm, ms_head.imm);
            chk("out_use_imm", out_use_imm, ms_head.uim);
        end
    endtask

    task automatic tick(input bit v, input op_t op, input logic [31:0] imm,
                        input bit uim, input bit ordy, input bit fl);
        uop_t u;
        in_valid   = v;
        in_op      = op;
        in_imm     = imm;
        in_use_imm = uim;
        out_ready  = ordy;
        flush      = fl;
        u.op  = op;
        u.imm = imm;
        u.uim = uim;
        #1;
        chk("in_ready", in_ready, (mq.size() < MAX_LEN) && !fl);
        if (out_valid && ordy) n_out += int'(out_len);
        model_step(v, u, ordy, fl);
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic feed(input op_t op, input bit ordy);
        bit imm_op;
        imm_op = (op == OP_INC) || (op == OP_SHL);
        tick(1'b1, op, imm_op ? 32'd1 : 32'd0, imm_op, ordy, 1'b0);
    endtask

    task automatic idle(input bit ordy);
        tick(1'b0, OP_NOP, 32'd0, 1'b0, ordy, 1'b0);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_op      = OP_NOP;
        in_imm     = '0;
        in_use_imm = 1'b0;
        flush      = 1'b0;
        out_ready  = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_len", out_len, 0);
        chk("rst_out_case", out_case, 0);
        chk("rst_out_op", out_op, OP_NOP);
        chk("rst_in_ready", in_ready, 1);

        feed(OP_IMUL, 1'b1);
        chk("imul_wait", out_valid, 0);
        feed(OP_ADD, 1'b1);
        chk("c0_valid", out_valid, 1);
        chk("c0_fused", out_fused, 1);
        chk("c0_case", out_case, 0);
        chk("c0_len", out_len, 2);

        feed(OP_AND, 1'b1);
        feed(OP_AND, 1'b1);
        chk("c1_case", out_case, 1);
        chk("c1_len", out_len, 2);
        feed(OP_INC, 1'b1);
        feed(OP_SHL, 1'b1);
        chk("c2_case", out_case, 2);
        chk("c2_fused", out_fused, 1);

        feed(OP_INC, 1'b1);
        feed(OP_ADD, 1'b1);
        chk("inc_single", out_fused, 0);
        chk("inc_len", out_len, 1);
        chk("inc_op", out_op, OP_INC);
        idle(1'b1);
        chk("add_single_valid", out_valid, 1);
        chk("add_single_op", out_op, OP_ADD);
        idle(1'b1);

        feed(OP_IMUL, 1'b1);
        repeat (7) idle(1'b1);
        chk("tmo_early", out_valid, 0);
        idle(1'b1);
        chk("tmo_valid", out_valid, 1);
        chk("tmo_op", out_op, OP_IMUL);
        chk("tmo_fused", out_fused, 0);
        feed(OP_ADD, 1'b1);
        chk("post_tmo_op", out_op, OP_ADD);
        chk("post_tmo_fused", out_fused, 0);
        idle(1'b1);

        feed(OP_IMUL, 1'b0);
        feed(OP_ADD, 1'b0);
        feed(OP_AND, 1'b0);
        feed(OP_OR, 1'b0);
        chk("full_in_ready", in_ready, 0);
        chk("hold_case", out_case, 0);
        chk("hold_fused", out_fused, 1);
        idle(1'b0);
        chk("hold_valid", out_valid, 1);
        chk("hold_case2", out_case, 0);
        idle(1'b1);
        chk("rel_and_op", out_op, OP_AND);
        chk("rel_and_fused", out_fused, 0);
        idle(1'b1);
        chk("rel_or_op", out_op, OP_OR);
        idle(1'b1);
        chk("rel_empty", out_valid, 0);

        feed(OP_IMUL, 1'b1);
        tick(1'b1, OP_ADD, 32'd0, 1'b0, 1'b1, 1'b1);
        chk("flush_op", out_op, OP_IMUL);
        chk("flush_fused", out_fused, 0);
        idle(1'b1);
        chk("flush_blocked", out_valid, 0);

        feed(OP_IMUL, 1'b1);
        feed(OP_ADD, 1'b1);
        feed(OP_AND, 1'b0);
        chk("pre_rst_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_ready", in_ready, 1);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        feed(OP_SHL, 1'b1);
        chk("midrst_shl_op", out_op, OP_SHL);
        chk("midrst_shl_fused", out_fused, 0);

        for (int n = 0; n < 3000; n++) begin
            bit  quiet;
            bit  v;
            op_t op;
            quiet = ((n / 150) % 3) == 2;
            v  = quiet ? ($urandom_range(0, 15) == 0)
                       : ($urandom_range(0, 3) != 0);
            op = op_t'($urandom_range(0, 7));
            tick(v, op, 32'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
            if (n == 1500) begin
                chk("conserve_mid",
                    n_out + mq.size() + (ms_valid ? ms_len : 0), n_acc);
                do_reset();
                compare();
            end
        end
        repeat (12) idle(1'b1);
        chk("conserve_end", n_out + mq.size() + (ms_valid ? ms_len : 0),
            n_acc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
